phase_result_collector: RTL and testbench
=========================================

// Module: phase_result_collector
// PURPOSE
// - Downstream of the elimination phase. Watches its per-lane memory stream (N data bits plus 3 op bits per lane) during a phase.
// - Captures every word marked as a write, packs R consecutive words into one N*R-bit beat, and buffers beats in a FIFO.
// - Drains the FIFO to the host over valid/ready, closing each phase with a flushed, tagged last beat.
// PARAMETERS
// - N      4   systolic lane count; width of one captured word
// - R      4   words packed per output beat (R >= 1); out_data width = N*R
// - DEPTH  16  FIFO depth in beats; power of two, >= 2
// - K      16  matrix column count; used only for the phase column-block tag width
// PORTS
// - clk          in   1                  clock, rising edge
// - rst          in   1                  synchronous, active-high reset
// - phase_start  in   1                  one-cycle pulse; the phase begins
// - phase_block  in   $clog2(K/N+1)      start block; sampled on phase_start
// - phase_done   in   1                  one-cycle pulse; the phase ends
// - mem_data_in  in   N                  lane data from the phase
// - mem_op_in    in   3*N                lane ops; lane i owns bits [3i+2:3i]
// - out_data     out  N*R                packed beat; word 0 occupies the LSBs
// - out_last     out  1                  beat is the final beat of its phase
// - out_block    out  $clog2(K/N+1)      phase_block tag carried with the beat
// - out_valid    out  1                  beat available
// - out_ready    in   1                  host accepts the beat
// - busy         out  1                  phase active, or FIFO not empty
// - overflow     out  1                  sticky; a beat was dropped because the FIFO was full
// BEHAVIOUR
// - Reset values: out_valid=0, out_last=0, busy=0, overflow=0, out_data=0, out_block=0. Reset empties the FIFO and the packer, and sets FSM=IDLE.
// - Reset mid-phase discards all partial and buffered data. No beat is emitted for the aborted phase.
// - Capture qualifier: cap = ACTIVE && |{mem_op_in[3i+2]} over lanes i. When cap=1, mem_data_in is registered into packer slot cnt.
// - Packer: counter cnt runs 0..R-1.
//   - When cap fires with cnt==R-1, the beat is complete and is pushed with last=0; cnt returns to 0.
// - FSM states and transitions:
//   - IDLE -> ACTIVE on phase_start. Latches phase_block; cnt=0.
//   - ACTIVE -> FLUSH on phase_done. A capture in the same cycle as phase_done is included.
//   - FLUSH, one cycle: pushes the current beat with last=1.
//     - Unfilled slots are zero.
//     - If cnt==0 and no words remain pending, it pushes an all-zero beat with last=1, so every phase yields exactly one last beat.
//     - Then -> IDLE.
//   - When the complete beat and phase_done coincide with cnt==R-1:
//     - the full beat is pushed with last=0 in the ACTIVE cycle;
//     - FLUSH then pushes a zero beat with last=1.
//   - phase_start in FLUSH or ACTIVE is ignored.
// - FIFO: first-word-fall-through. Each entry is {last, block, data}.
//   - out_valid = !empty. A pop occurs when out_valid && out_ready.
//   - out_* are driven straight from the head entry and stay stable while out_valid && !out_ready.
//   - Push and pop in the same cycle are legal when full: the pop frees the slot and the push succeeds, with no overflow.
//   - Push while full without a pop drops the beat and sets overflow. overflow clears only on rst.
//   - A dropped last beat is still dropped. The FSM still returns to IDLE.
// - Latency: a word captured at cycle t can complete a beat that is visible on out_valid at t+2: packer register, then FIFO write.
// - busy = (FSM != IDLE) || !empty.
// STRUCTURE
// - Shared package:
//   - op field localparams: OP_W=3, OP_WR_BIT=2
//   - FSM state enum: IDLE, ACTIVE, FLUSH
//   - the block-tag width function, shared with the phase/step hierarchy
// - One sub-module: sync_fifo_fwft (WIDTH = 1 + tag width + N*R, DEPTH). Provides full/empty plus same-cycle push/pop.
// - Packer and FSM stay in this module.
// TESTING
// - N=4, R=4: start with block=2; write ops on words 0x1,0x2,0x3,0x4; done -> one beat, data=0x4321, last=0, block=2; then a zero beat with last=1.
// - Start; capture 0xA, 0xB; done -> single beat, data=0x00BA, last=1; busy falls the cycle after that beat is popped.
// - Start, then immediate done with no captures -> exactly one beat, data=0, last=1.
// - DEPTH=2, out_ready=0, 12 words captured -> two beats held; the third beat is dropped and overflow=1. Raise out_ready -> both held beats drain in order, unchanged.
// - FIFO full, with a push and out_ready=1 in the same cycle -> no overflow; occupancy stays 2.
// - rst pulsed mid-phase after 2 captures -> out_valid=0 and busy=0 the next cycle. A new phase then packs from slot 0.

Source files
------------

// File: rtl/phase_result_collector_pkg.sv
// phase_result_collector_pkg: shared op-field constants, FSM states and block-tag width helper
package phase_result_collector_pkg;
   localparam int OP_W = 3;
   localparam int OP_WR_BIT = 2;
   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
   function automatic int tag_w(input int k, input int n);
      return $clog2(k / n + 1);
   endfunction
endpackage

// File: rtl/phase_result_collector_if.sv
// phase_result_collector_if: host-side beat stream
//   out_data  packed beat, word 0 in the LSBs
//   out_last  final beat of its phase
//   out_block phase block tag
//   out_valid beat available
//   out_ready host accepts the beat
interface phase_result_collector_if #(
   parameter int DW = 16,
   parameter int TW = 3
);
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [TW-1:0] out_block;
   logic          out_valid;
   logic          out_ready;
   modport master (output out_data, out_last, out_block, out_valid, input out_ready);
   modport slave (input out_data, out_last, out_block, out_valid, output out_ready);
endinterface

// File: rtl/phase_result_collector_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO with same-cycle push/pop when full
//   push_i/push_data_i write side, pop_i read side (ignored when empty)
//   rd_data_o head entry (zero when empty), full_o/empty_o occupancy flags
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, rp_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;
   assign full_o    = cnt_q == (AW+1)'(DEPTH);
   assign empty_o   = cnt_q == '0;
   assign do_pop    = pop_i && !empty_o;
   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign do_push   = push_i && (!full_o || do_pop);
   assign rd_data_o = empty_o ? '0 : mem_q[rp_q];
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= push_data_i;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= do_push ? wp_q + 1'b1 : wp_q;
         rp_q  <= do_pop ? rp_q + 1'b1 : rp_q;
         cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
endmodule

// File: rtl/phase_result_collector.sv
// phase_result_collector: packs written lane words into beats, buffers them and drains to the host
//   phase_start/phase_block/phase_done  phase control; block tag latched on start
//   mem_data_in/mem_op_in               per-lane word and ops; any lane write bit captures the word
//   out_if                              beat stream {out_data, out_last, out_block} with valid/ready
//   busy                                phase active, beat in flight, or FIFO not empty
//   overflow                            sticky; a beat was dropped on a full FIFO
module phase_result_collector
   import phase_result_collector_pkg::*;
#(
   parameter int N     = 4,
   parameter int R     = 4,
   parameter int DEPTH = 16,
   parameter int K     = 16,
   localparam int TW   = tag_w(K, N),
   localparam int DW   = N * R
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 phase_start,
   input  logic [TW-1:0]        phase_block,
   input  logic                 phase_done,
   input  logic [N-1:0]         mem_data_in,
   input  logic [OP_W*N-1:0]    mem_op_in,
   phase_result_collector_if.master out_if,
   output logic                 busy,
   output logic                 overflow
);
   localparam int CW = R > 1 ? $clog2(R) : 1;
   localparam int FW = 1 + TW + DW;
   state_t        state_q, state_d;
   logic [DW-1:0] pack_q, pack_d, pack_w;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] blk_q, blk_d;
   logic          push_q, push_d;
   logic [FW-1:0] beat_q, beat_d, head;
   logic          ovf_q, ovf_d;
   logic          wr, cap, start, flush, full_word, clear, pop, full, empty;
   logic          unused_op;
   assign unused_op = &{1'b0, mem_op_in};
   always_comb begin
      wr = 1'b0;
      for (int i = 0; i < N; i++) wr = wr | mem_op_in[OP_W*i+OP_WR_BIT];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pack_q  <= '0;
         cnt_q   <= '0;
         blk_q   <= '0;
         push_q  <= 1'b0;
         beat_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pack_q  <= pack_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         push_q  <= push_d;
         beat_q  <= beat_d;
         ovf_q   <= ovf_d;
      end
   end
   always_comb begin
      state_d = (state_q == IDLE && phase_start) ? ACTIVE :
                (state_q == ACTIVE && phase_done) ? FLUSH :
                (state_q == FLUSH) ? IDLE : state_q;
   end
   always_comb begin
      start     = state_q == IDLE && phase_start;
      flush     = state_q == FLUSH;
      cap       = state_q == ACTIVE && wr;
      full_word = cap && cnt_q == CW'(R - 1);
      // slots beyond cnt are always zero, so OR-ing in the new word is enough
      pack_w    = cap ? pack_q | (DW'(mem_data_in) << (cnt_q * N)) : pack_q;
      clear     = full_word || flush || start;
      pack_d    = clear ? '0 : pack_w;
      cnt_d     = clear ? '0 : cap ? cnt_q + 1'b1 : cnt_q;
      blk_d     = start ? phase_block : blk_q;
      // beats go through one register before the FIFO write
      push_d    = full_word || flush;
      beat_d    = {flush, blk_q, pack_w};
      pop       = out_if.out_valid && out_if.out_ready;
      ovf_d     = ovf_q || (push_q && full && !pop);
   end
   sync_fifo_fwft #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_q),
      .push_data_i (beat_q),
      .pop_i       (pop),
      .rd_data_o   (head),
      .full_o      (full),
      .empty_o     (empty)
   );
   assign out_if.out_valid = !empty;
   assign {out_if.out_last, out_if.out_block, out_if.out_data} = head;
   // a beat still in the write register counts as work so busy never dips after FLUSH
   assign busy     = state_q != IDLE || push_q || !empty;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_phase_result_collector.sv
// tb_phase_result_collector: directed stimulus with a queued scoreboard for phase_result_collector
module tb_phase_result_collector;
   import phase_result_collector_pkg::*;
   localparam int N = 4, R = 4, DEPTH = 2, K = 16;
   localparam int TW = tag_w(K, N), DW = N * R;
   logic              clk = 1'b0, rst = 1'b1;
   logic              phase_start = 1'b0, phase_done = 1'b0;
   logic [TW-1:0]     phase_block = '0;
   logic [N-1:0]      mem_data_in = '0;
   logic [3*N-1:0]    mem_op_in = '0;
   logic              busy, overflow;
   logic [TW+DW:0]    exp_q [$];
   logic [TW+DW:0]    e;
   int                vecs = 0, miss = 0;
   phase_result_collector_if #(.DW(DW), .TW(TW)) bus ();
   phase_result_collector #(.N(N), .R(R), .DEPTH(DEPTH), .K(K)) dut (
      .clk         (clk),
      .rst         (rst),
      .phase_start (phase_start),
      .phase_block (phase_block),
      .phase_done  (phase_done),
      .mem_data_in (mem_data_in),
      .mem_op_in   (mem_op_in),
      .out_if      (bus),
      .busy        (busy),
      .overflow    (overflow)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vecs++;
      if (act !== req) begin
         miss++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            vecs++;
            miss++;
            $display("FAIL beat: unexpected beat %h expected none", {bus.out_last, bus.out_block, bus.out_data});
         end else begin
            e = exp_q.pop_front();
            check("beat", 32'({bus.out_last, bus.out_block, bus.out_data}), 32'(e));
         end
      end
   end
   task automatic cyc(input logic ps, input logic [TW-1:0] blk, input logic pd, input logic [N-1:0] d, input logic [3*N-1:0] op);
      phase_start = ps;
      phase_block = blk;
      phase_done  = pd;
      mem_data_in = d;
      mem_op_in   = op;
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(1'b0, '0, 1'b0, '0, '0);
   endtask
   task automatic start(input logic [TW-1:0] blk);
      cyc(1'b1, blk, 1'b0, '0, '0);
   endtask
   task automatic done();
      cyc(1'b0, '0, 1'b1, '0, '0);
   endtask
   // the write bit is placed in a lane chosen by the word value to exercise the lane OR
   task automatic wr(input logic [N-1:0] d, input logic pd = 1'b0);
      logic [3*N-1:0] op;
      op = '0;
      op[3*d[1:0]+2] = 1'b1;
      cyc(1'b0, '0, pd, d, op);
   endtask
   task automatic expect_beat(input logic last, input logic [TW-1:0] blk, input logic [DW-1:0] data);
      exp_q.push_back({last, blk, data});
   endtask
   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         idle(1);
         t++;
      end
      check(name, 32'(exp_q.size()), 0);
      exp_q.delete();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end
   initial begin
      int t;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      idle(3);
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_last", 32'(bus.out_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_data", 32'(bus.out_data), 0);
      check("rst_block", 32'(bus.out_block), 0);
      rst = 1'b0;
      expect_beat(1'b0, 3'd2, 16'h4321);
      expect_beat(1'b1, 3'd2, 16'h0000);
      start(3'd2);
      wr(4'h1);
      cyc(1'b1, 3'd7, 1'b0, 4'hF, 12'h6DB);
      wr(4'h2);
      wr(4'h3);
      wr(4'h4);
      done();
      drain("drain_full_beat");
      expect_beat(1'b0, 3'd4, 16'h8765);
      expect_beat(1'b1, 3'd4, 16'h0000);
      start(3'd4);
      wr(4'h5);
      wr(4'h6);
      wr(4'h7);
      wr(4'h8, 1'b1);
      drain("drain_coincide");
      expect_beat(1'b1, 3'd1, 16'h00BA);
      start(3'd1);
      wr(4'hA);
      wr(4'hB);
      done();
      t = 0;
      while (!bus.out_valid && t < 20) begin
         idle(1);
         t++;
      end
      check("partial_valid", 32'(bus.out_valid), 1);
      check("partial_busy_hold", 32'(busy), 1);
      idle(1);
      check("partial_busy_fall", 32'(busy), 0);
      check("partial_empty", 32'(bus.out_valid), 0);
      expect_beat(1'b1, 3'd3, 16'h0000);
      start(3'd3);
      done();
      drain("drain_empty_phase");
      idle(5);
      check("empty_phase_single", 32'(bus.out_valid), 0);
      start(3'd5);
      wr(4'h1);
      wr(4'h2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("abort_valid", 32'(bus.out_valid), 0);
      check("abort_busy", 32'(busy), 0);
      expect_beat(1'b1, 3'd6, 16'h00DC);
      start(3'd6);
      wr(4'hC);
      wr(4'hD);
      done();
      drain("drain_after_abort");
      idle(3);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      bus.out_ready = 1'b0;
      start(3'd1);
      for (int i = 1; i <= 12; i++) wr(4'(i));
      idle(3);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_hold_valid", 32'(bus.out_valid), 1);
      check("ovf_hold_data", 32'(bus.out_data), 32'h4321);
      done();
      idle(4);
      expect_beat(1'b0, 3'd1, 16'h4321);
      expect_beat(1'b0, 3'd1, 16'h8765);
      bus.out_ready = 1'b1;
      drain("drain_ovf");
      idle(4);
      check("ovf_drained", 32'(bus.out_valid), 0);
      check("ovf_idle_busy", 32'(busy), 0);
      check("ovf_sticky", 32'(overflow), 1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      bus.out_ready = 1'b0;
      start(3'd2);
      for (int i = 1; i <= 12; i++) wr(4'(i));
      expect_beat(1'b0, 3'd2, 16'h4321);
      bus.out_ready = 1'b1;
      idle(1);
      bus.out_ready = 1'b0;
      check("full_pop_no_ovf", 32'(overflow), 0);
      check("full_pop_head", 32'(bus.out_data), 32'h8765);
      expect_beat(1'b0, 3'd2, 16'h8765);
      expect_beat(1'b0, 3'd2, 16'hCBA9);
      done();
      idle(4);
      check("last_dropped_ovf", 32'(overflow), 1);
      bus.out_ready = 1'b1;
      drain("drain_full_pop");
      idle(4);
      check("full_pop_drained", 32'(bus.out_valid), 0);
      check("full_pop_busy", 32'(busy), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
